// File: rtl/riscv_ckpt_pkg.sv
// riscv_ckpt_pkg: shared STATUS codes and FSM state encoding for the
// RISC-V checkpoint monitor.
package riscv_ckpt_pkg;

    localparam logic [2:0] CKPT_ST_NONE       = 3'd0;
    localparam logic [2:0] CKPT_ST_PASS       = 3'd1;
    localparam logic [2:0] CKPT_ST_MISMATCH   = 3'd2;
    localparam logic [2:0] CKPT_ST_SKIP       = 3'd3;
    localparam logic [2:0] CKPT_ST_INCOMPLETE = 3'd4;
    localparam logic [2:0] CKPT_ST_TIMEOUT    = 3'd5;

    typedef enum logic [1:0] {
        CKPT_IDLE = 2'd0,
        CKPT_RUN  = 2'd1,
        CKPT_DONE = 2'd2
    } ckpt_state_t;

endpackage

// File: rtl/riscv_ckpt_table.sv
// riscv_ckpt_table: checkpoint table of (instruction count, expected value)
// pairs. One write port, combinational read. Contents are never reset.
module riscv_ckpt_table #(
    parameter int NUM_CKPT = 40,
    parameter int IDX_W    = 6,
    parameter int DWIDTH   = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DWIDTH-1:0] winst,
    input  logic [DWIDTH-1:0] wans,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DWIDTH-1:0] rinst,
    output logic [DWIDTH-1:0] rans
);

    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_CKPT);

    logic [2*DWIDTH-1:0] mem [NUM_CKPT];

    // Table write; indices beyond the table depth are dropped.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DEPTH)) begin
            mem[waddr] <= {winst, wans};
        end
    end

    // Combinational read of the entry currently under test.
    always_comb begin
        rinst = '0;
        rans  = '0;
        if ({1'b0, raddr} < DEPTH) begin
            {rinst, rans} = mem[raddr];
        end
    end

endmodule

// File: rtl/riscv_ckpt_monitor.sv
// riscv_ckpt_monitor: watches NUM_INST/OUTPUT_PORT/HALT from the core and
// checks OUTPUT_PORT against a programmed checkpoint table.
// Optional macro RISCV_CKPT_MON_CONTINUE_EN: mismatches are counted and the
// run continues; the verdict is given at HALT.
module riscv_ckpt_monitor
    import riscv_ckpt_pkg::*;
#(
    parameter int          NUM_CKPT   = 40,
    parameter int          IDX_W      = 6,
    parameter int          DWIDTH     = 32,
    parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CKPT_WE,
    input  logic [IDX_W-1:0]  CKPT_WADDR,
    input  logic [DWIDTH-1:0] CKPT_WINST,
    input  logic [DWIDTH-1:0] CKPT_WANS,
    input  logic [IDX_W:0]    CKPT_NUM,
    input  logic              START,
    input  logic [DWIDTH-1:0] NUM_INST,
    input  logic [DWIDTH-1:0] OUTPUT_PORT,
    input  logic              HALT,
    output logic              BUSY,
    output logic              DONE,
    output logic [2:0]        STATUS,
    output logic [IDX_W-1:0]  FAIL_IDX,
    output logic [DWIDTH-1:0] FAIL_GOT,
    output logic [DWIDTH-1:0] FAIL_EXP,
    output logic [IDX_W:0]    PASS_CNT,
    output logic [IDX_W:0]    FAIL_CNT,
    output logic [DWIDTH-1:0] CYCLE
);

    // CYCLE value whose arrival ends a run as TIMEOUT.
    localparam logic [DWIDTH-1:0] TIMEOUT_AT = DWIDTH'(MAX_CYCLES - 32'd1);

    ckpt_state_t       state_reg, state_next;
    logic [IDX_W:0]    n_ckpt_reg, n_ckpt_next;
    logic [IDX_W:0]    ptr_reg, ptr_next;
    logic [IDX_W:0]    pass_cnt_reg, pass_cnt_next;
    logic [IDX_W:0]    fail_cnt_reg, fail_cnt_next;
    logic [2:0]        status_reg, status_next;
    logic [IDX_W-1:0]  fail_idx_reg, fail_idx_next;
    logic [DWIDTH-1:0] fail_got_reg, fail_got_next;
    logic [DWIDTH-1:0] fail_exp_reg, fail_exp_next;
    logic [DWIDTH-1:0] cycle_reg, cycle_next;
    logic              stop;

    logic [DWIDTH-1:0] cur_inst;
    logic [DWIDTH-1:0] cur_ans;
    logic              table_we;

    // The table is only writable while idle.
    assign table_we = CKPT_WE && (state_reg == CKPT_IDLE);

    riscv_ckpt_table #(
        .NUM_CKPT (NUM_CKPT),
        .IDX_W    (IDX_W),
        .DWIDTH   (DWIDTH)
    ) u_table (
        .clk   (CLK),
        .we    (table_we),
        .waddr (CKPT_WADDR),
        .winst (CKPT_WINST),
        .wans  (CKPT_WANS),
        .raddr (ptr_reg[IDX_W-1:0]),
        .rinst (cur_inst),
        .rans  (cur_ans)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg <= CKPT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, pointer and failure record registers.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            n_ckpt_reg   <= '0;
            ptr_reg      <= '0;
            pass_cnt_reg <= '0;
            fail_cnt_reg <= '0;
            status_reg   <= CKPT_ST_NONE;
            fail_idx_reg <= '0;
            fail_got_reg <= '0;
            fail_exp_reg <= '0;
            cycle_reg    <= '0;
        end else begin
            n_ckpt_reg   <= n_ckpt_next;
            ptr_reg      <= ptr_next;
            pass_cnt_reg <= pass_cnt_next;
            fail_cnt_reg <= fail_cnt_next;
            status_reg   <= status_next;
            fail_idx_reg <= fail_idx_next;
            fail_got_reg <= fail_got_next;
            fail_exp_reg <= fail_exp_next;
            cycle_reg    <= cycle_next;
        end
    end

    // Next-state logic: checkpoint compare first, then HALT, then timeout.
    always_comb begin
        state_next    = state_reg;
        n_ckpt_next   = n_ckpt_reg;
        ptr_next      = ptr_reg;
        pass_cnt_next = pass_cnt_reg;
        fail_cnt_next = fail_cnt_reg;
        status_next   = status_reg;
        fail_idx_next = fail_idx_reg;
        fail_got_next = fail_got_reg;
        fail_exp_next = fail_exp_reg;
        cycle_next    = cycle_reg;
        stop          = 1'b0;

        case (state_reg)
            CKPT_IDLE, CKPT_DONE: begin
                if (START) begin
                    state_next    = CKPT_RUN;
                    n_ckpt_next   = CKPT_NUM;
                    ptr_next      = '0;
                    pass_cnt_next = '0;
                    fail_cnt_next = '0;
                    status_next   = CKPT_ST_NONE;
                    fail_idx_next = '0;
                    fail_got_next = '0;
                    fail_exp_next = '0;
                    cycle_next    = '0;
                end
            end

            CKPT_RUN: begin
                if (cycle_reg != '1) begin
                    cycle_next = cycle_reg + 1'b1;
                end

                if (ptr_reg < n_ckpt_reg) begin
                    if (NUM_INST == cur_inst) begin
                        if (OUTPUT_PORT == cur_ans) begin
                            ptr_next      = ptr_reg + 1'b1;
                            pass_cnt_next = pass_cnt_reg + 1'b1;
                        end else begin
                            // Only the first failure is recorded.
                            if (fail_cnt_reg == '0) begin
                                fail_idx_next = ptr_reg[IDX_W-1:0];
                                fail_got_next = OUTPUT_PORT;
                                fail_exp_next = cur_ans;
                            end
                            fail_cnt_next = fail_cnt_reg + 1'b1;
`ifdef RISCV_CKPT_MON_CONTINUE_EN
                            ptr_next = ptr_reg + 1'b1;
`else
                            stop        = 1'b1;
                            status_next = CKPT_ST_MISMATCH;
`endif
                        end
                    end else if (NUM_INST > cur_inst) begin
                        // The core retired past this checkpoint without
                        // presenting it.
                        if (fail_cnt_reg == '0) begin
                            fail_idx_next = ptr_reg[IDX_W-1:0];
                            fail_got_next = OUTPUT_PORT;
                            fail_exp_next = cur_ans;
                        end
                        stop        = 1'b1;
                        status_next = CKPT_ST_SKIP;
                    end
                end

                if (!stop) begin
                    if (HALT) begin
                        stop = 1'b1;
`ifdef RISCV_CKPT_MON_CONTINUE_EN
                        if (fail_cnt_next != '0) begin
                            status_next = CKPT_ST_MISMATCH;
                        end else
`endif
                        if (ptr_next == n_ckpt_reg) begin
                            status_next = CKPT_ST_PASS;
                        end else begin
                            status_next = CKPT_ST_INCOMPLETE;
                        end
                    end else if (cycle_next == TIMEOUT_AT) begin
                        stop        = 1'b1;
                        status_next = CKPT_ST_TIMEOUT;
                    end
                end

                if (stop) begin
                    state_next = CKPT_DONE;
                end
            end

            default: begin
                state_next = CKPT_IDLE;
            end
        endcase
    end

    assign BUSY     = (state_reg == CKPT_RUN);
    assign DONE     = (state_reg == CKPT_DONE);
    assign STATUS   = status_reg;
    assign FAIL_IDX = fail_idx_reg;
    assign FAIL_GOT = fail_got_reg;
    assign FAIL_EXP = fail_exp_reg;
    assign PASS_CNT = pass_cnt_reg;
    assign FAIL_CNT = fail_cnt_reg;
    assign CYCLE    = cycle_reg;

endmodule
